// File: rtl/acc_ctrl_fsm.sv
// Multicycle control FSM for the 16-bit accumulator processor.
// Moore-style control decoded from the state register; only the BRANCH PC write looks at Zero.
module acc_ctrl_fsm (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic        Zero,
    output logic [2:0]  ALUSrcA,
    output logic [3:0]  ALUSrcB,
    output logic [2:0]  ALUOP,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        IRWrite,
    output logic [1:0]  IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        ACCWrite,
    output logic        ACCSrc,
    output logic        SPWrite,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_RD  = 4'd2,
        S_MEM_ALU = 4'd3,
        S_LOAD_WB = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXEC_I  = 4'd6,
        S_BRANCH  = 4'd7,
        S_JUMP    = 4'd8,
        S_SP_DEC  = 4'd9,
        S_PUSH_WR = 4'd10,
        S_POP_RD  = 4'd11,
        S_POP_WB  = 4'd12,
        S_HALT    = 4'd15
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  opcode;
    logic [11:0] unused_ir;

    assign opcode    = IR[15:12];
    assign unused_ir = IR[11:0];

    always_ff @(posedge CLK) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // While reset is low every output is held at its idle value, so an
    // interrupted instruction cannot finish any write it had in progress.
    always_comb begin
        state_d  = state_q;
        State    = 4'd0;
        ALUSrcA  = 3'd0;
        ALUSrcB  = 4'd0;
        ALUOP    = 3'b000;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 2'd0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ACCWrite = 1'b0;
        ACCSrc   = 1'b0;
        SPWrite  = 1'b0;
        if (reset) begin
            State = state_q;
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    ALUSrcB = 4'd4;
                    case (opcode)
                        4'h0, 4'h1, 4'h2, 4'h3, 4'h4: state_d = S_MEM_RD;
                        4'h5:    state_d = S_MEM_WR;
                        4'h6:    state_d = S_EXEC_I;
                        4'h7:    state_d = S_BRANCH;
                        4'h8:    state_d = S_JUMP;
                        4'h9:    state_d = S_SP_DEC;
                        4'hA:    state_d = S_POP_RD;
                        4'hF:    state_d = S_HALT;
                        default: state_d = S_FETCH;
                    endcase
                end
                S_MEM_RD: begin
                    IorD    = 2'd2;
                    MemRead = 1'b1;
                    state_d = (opcode == 4'h4) ? S_LOAD_WB : S_MEM_ALU;
                end
                S_MEM_ALU: begin
                    ALUSrcA  = 3'd1;
                    ALUSrcB  = 4'd2;
                    ALUOP    = {1'b0, opcode[1:0]};
                    ACCWrite = 1'b1;
                    state_d  = S_FETCH;
                end
                S_LOAD_WB: begin
                    ACCWrite = 1'b1;
                    ACCSrc   = 1'b1;
                    state_d  = S_FETCH;
                end
                S_MEM_WR: begin
                    IorD     = 2'd2;
                    MemWrite = 1'b1;
                    state_d  = S_FETCH;
                end
                S_EXEC_I: begin
                    ALUSrcA  = 3'd1;
                    ALUSrcB  = 4'd1;
                    ACCWrite = 1'b1;
                    state_d  = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA = 3'd1;
                    ALUOP   = 3'b101;
                    PCSrc   = 1'b1;
                    PCWrite = Zero;
                    state_d = S_FETCH;
                end
                S_JUMP: begin
                    PCSrc   = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_FETCH;
                end
                S_SP_DEC: begin
                    ALUSrcA = 3'd2;
                    ALUOP   = 3'b001;
                    SPWrite = 1'b1;
                    state_d = S_PUSH_WR;
                end
                S_PUSH_WR: begin
                    IorD     = 2'd1;
                    MemWrite = 1'b1;
                    state_d  = S_FETCH;
                end
                S_POP_RD: begin
                    IorD    = 2'd1;
                    MemRead = 1'b1;
                    state_d = S_POP_WB;
                end
                S_POP_WB: begin
                    ACCWrite = 1'b1;
                    ACCSrc   = 1'b1;
                    ALUSrcA  = 3'd2;
                    SPWrite  = 1'b1;
                    state_d  = S_FETCH;
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_ctrl_fsm.sv
// Directed bench for acc_ctrl_fsm: walks each instruction class through its
// state sequence and checks the control outputs in every state.
module tb_acc_ctrl_fsm;

    logic        CLK;
    logic        reset;
    logic [15:0] IR;
    logic        Zero;
    logic [2:0]  ALUSrcA;
    logic [3:0]  ALUSrcB;
    logic [2:0]  ALUOP;
    logic        PCWrite;
    logic        PCSrc;
    logic        IRWrite;
    logic [1:0]  IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        ACCWrite;
    logic        ACCSrc;
    logic        SPWrite;
    logic [3:0]  State;

    int checks = 0;
    int errors = 0;

    // {PCWrite, IRWrite, MemRead, MemWrite, ACCWrite, SPWrite}
    logic [5:0] en;
    assign en = {PCWrite, IRWrite, MemRead, MemWrite, ACCWrite, SPWrite};

    acc_ctrl_fsm dut (
        .CLK(CLK), .reset(reset), .IR(IR), .Zero(Zero),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOP(ALUOP),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .ACCWrite(ACCWrite),
        .ACCSrc(ACCSrc), .SPWrite(SPWrite), .State(State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; IR = 16'h0000; Zero = 1'b0;
        step(); step();
        reset = 1'b1; IR = 16'hA000;
        #1;
        checks++; if (State !== 4'd0) begin errors++; $display("FAIL rst_fetch_state: got %0d want 0", State); end
        step(); step(); step();
        checks++; if (State !== 4'd12) begin errors++; $display("FAIL rst_reach_popwb: got %0d want 12", State); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (State !== 4'd0) begin errors++; $display("FAIL rst_hold_state[%0d]: got %0d want 0", i, State); end
            checks++; if (en !== 6'b0 || ACCSrc !== 1'b0 || ALUSrcA !== 3'd0 || ALUOP !== 3'd0) begin
                errors++; $display("FAIL rst_hold_outputs[%0d]: en=%b accsrc=%b srca=%0d op=%0d want all 0", i, en, ACCSrc, ALUSrcA, ALUOP); end
            step();
        end
        reset = 1'b1; IR = 16'h0000;
        #1;
        checks++; if (State !== 4'd0 || MemRead !== 1'b1 || IRWrite !== 1'b1 || PCWrite !== 1'b1 || PCSrc !== 1'b0) begin
            errors++; $display("FAIL rst_first_fetch: state=%0d mr=%b irw=%b pcw=%b pcsrc=%b want 0 1 1 1 0", State, MemRead, IRWrite, PCWrite, PCSrc); end
        checks++; if (IorD !== 2'd0 || ALUSrcB !== 4'd0 || ALUOP !== 3'b000 || ACCWrite !== 1'b0) begin
            errors++; $display("FAIL rst_fetch_sel: iord=%0d srcb=%0d op=%0d accw=%b want 0 0 0 0", IorD, ALUSrcB, ALUOP, ACCWrite); end
    endtask

    task automatic test_mem_alu();
        logic [15:0] irs [4]  = '{16'h0010, 16'h1034, 16'h2020, 16'h3030};
        logic [2:0]  ops [4]  = '{3'b000, 3'b001, 3'b010, 3'b011};
        for (int k = 0; k < 4; k++) begin
            IR = irs[k];
            checks++; if (State !== 4'd0) begin errors++; $display("FAIL alu%0d_s0: got %0d want 0", k, State); end
            step();
            checks++; if (State !== 4'd1 || ALUSrcB !== 4'd4 || ALUSrcA !== 3'd0 || ALUOP !== 3'b000 || en !== 6'b0) begin
                errors++; $display("FAIL alu%0d_decode: state=%0d srcb=%0d srca=%0d op=%0d en=%b want 1 4 0 0 0", k, State, ALUSrcB, ALUSrcA, ALUOP, en); end
            step();
            checks++; if (State !== 4'd2 || IorD !== 2'd2 || en !== 6'b001000) begin
                errors++; $display("FAIL alu%0d_memrd: state=%0d iord=%0d en=%b want 2 2 001000", k, State, IorD, en); end
            step();
            checks++; if (State !== 4'd3 || ALUSrcA !== 3'd1 || ALUSrcB !== 4'd2 || ALUOP !== ops[k] || en !== 6'b000010 || ACCSrc !== 1'b0) begin
                errors++; $display("FAIL alu%0d_exec: state=%0d srca=%0d srcb=%0d op=%0d en=%b accsrc=%b want 3 1 2 %0d 000010 0", k, State, ALUSrcA, ALUSrcB, ALUOP, en, ACCSrc, ops[k]); end
            step();
            checks++; if (State !== 4'd0) begin errors++; $display("FAIL alu%0d_return: got %0d want 0", k, State); end
        end
    endtask

    task automatic test_load();
        IR = 16'h4010;
        step();
        checks++; if (State !== 4'd1) begin errors++; $display("FAIL load_decode: got %0d want 1", State); end
        step();
        checks++; if (State !== 4'd2 || MemRead !== 1'b1 || IorD !== 2'd2) begin
            errors++; $display("FAIL load_memrd: state=%0d mr=%b iord=%0d want 2 1 2", State, MemRead, IorD); end
        step();
        checks++; if (State !== 4'd4 || ACCWrite !== 1'b1 || ACCSrc !== 1'b1 || MemRead !== 1'b0 || en !== 6'b000010) begin
            errors++; $display("FAIL load_wb: state=%0d accw=%b accsrc=%b mr=%b en=%b want 4 1 1 0 000010", State, ACCWrite, ACCSrc, MemRead, en); end
        step();
        checks++; if (State !== 4'd0) begin errors++; $display("FAIL load_return: got %0d want 0", State); end
    endtask

    task automatic test_store_addi_jump();
        IR = 16'h5010;
        step(); step();
        checks++; if (State !== 4'd5 || IorD !== 2'd2 || en !== 6'b000100) begin
            errors++; $display("FAIL store_wr: state=%0d iord=%0d en=%b want 5 2 000100", State, IorD, en); end
        step();
        checks++; if (State !== 4'd0) begin errors++; $display("FAIL store_return: got %0d want 0", State); end
        IR = 16'h6005;
        step(); step();
        checks++; if (State !== 4'd6 || ALUSrcA !== 3'd1 || ALUSrcB !== 4'd1 || ALUOP !== 3'b000 || en !== 6'b000010 || ACCSrc !== 1'b0) begin
            errors++; $display("FAIL addi_exec: state=%0d srca=%0d srcb=%0d op=%0d en=%b accsrc=%b want 6 1 1 0 000010 0", State, ALUSrcA, ALUSrcB, ALUOP, en, ACCSrc); end
        step();
        checks++; if (State !== 4'd0) begin errors++; $display("FAIL addi_return: got %0d want 0", State); end
        IR = 16'h8123;
        step(); step();
        checks++; if (State !== 4'd8 || PCSrc !== 1'b1 || en !== 6'b100000) begin
            errors++; $display("FAIL jump_exec: state=%0d pcsrc=%b en=%b want 8 1 100000", State, PCSrc, en); end
        step();
        checks++; if (State !== 4'd0) begin errors++; $display("FAIL jump_return: got %0d want 0", State); end
    endtask

    task automatic test_branch();
        logic zv [2] = '{1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            IR = 16'h7004; Zero = zv[k];
            step();
            checks++; if (State !== 4'd1) begin errors++; $display("FAIL br%0d_decode: got %0d want 1", k, State); end
            step();
            checks++; if (State !== 4'd7 || PCWrite !== zv[k] || PCSrc !== 1'b1 || ALUSrcA !== 3'd1 || ALUOP !== 3'b101) begin
                errors++; $display("FAIL br%0d_exec: state=%0d pcw=%b pcsrc=%b srca=%0d op=%0d want 7 %b 1 1 5", k, State, PCWrite, PCSrc, ALUSrcA, ALUOP, zv[k]); end
            checks++; if (en[4:0] !== 5'b0) begin errors++; $display("FAIL br%0d_other_en: got %b want 00000", k, en[4:0]); end
            if (k == 1) begin
                Zero = 1'b1; #1;
                checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL br_zero_comb: pcw=%b want 1", PCWrite); end
                Zero = 1'b0;
            end
            step();
            checks++; if (State !== 4'd0) begin errors++; $display("FAIL br%0d_return: got %0d want 0", k, State); end
        end
    endtask

    task automatic test_push_pop();
        IR = 16'h9000;
        step(); step();
        checks++; if (State !== 4'd9 || ALUSrcA !== 3'd2 || ALUSrcB !== 4'd0 || ALUOP !== 3'b001 || en !== 6'b000001) begin
            errors++; $display("FAIL push_spdec: state=%0d srca=%0d srcb=%0d op=%0d en=%b want 9 2 0 1 000001", State, ALUSrcA, ALUSrcB, ALUOP, en); end
        step();
        checks++; if (State !== 4'd10 || IorD !== 2'd1 || en !== 6'b000100) begin
            errors++; $display("FAIL push_wr: state=%0d iord=%0d en=%b want 10 1 000100", State, IorD, en); end
        step();
        checks++; if (State !== 4'd0) begin errors++; $display("FAIL push_return: got %0d want 0", State); end
        IR = 16'hA000;
        step(); step();
        checks++; if (State !== 4'd11 || IorD !== 2'd1 || en !== 6'b001000) begin
            errors++; $display("FAIL pop_rd: state=%0d iord=%0d en=%b want 11 1 001000", State, IorD, en); end
        step();
        checks++; if (State !== 4'd12 || ACCSrc !== 1'b1 || ALUOP !== 3'b000 || ALUSrcA !== 3'd2 || ALUSrcB !== 4'd0 || en !== 6'b000011) begin
            errors++; $display("FAIL pop_wb: state=%0d accsrc=%b op=%0d srca=%0d srcb=%0d en=%b want 12 1 0 2 0 000011", State, ACCSrc, ALUOP, ALUSrcA, ALUSrcB, en); end
        step();
        checks++; if (State !== 4'd0) begin errors++; $display("FAIL pop_return: got %0d want 0", State); end
    endtask

    task automatic test_illegal_halt();
        IR = 16'hC123;
        step();
        checks++; if (State !== 4'd1 || en !== 6'b0) begin errors++; $display("FAIL ill_decode: state=%0d en=%b want 1 000000", State, en); end
        step();
        checks++; if (State !== 4'd0) begin errors++; $display("FAIL ill_return: got %0d want 0", State); end
        IR = 16'hF000;
        step(); step();
        for (int i = 0; i < 20; i++) begin
            checks++; if (State !== 4'd15 || en !== 6'b0) begin
                errors++; $display("FAIL halt_hold[%0d]: state=%0d en=%b want 15 000000", i, State, en); end
            step();
        end
        reset = 1'b0;
        #1;
        checks++; if (State !== 4'd0 || en !== 6'b0) begin errors++; $display("FAIL halt_reset_comb: state=%0d en=%b want 0 000000", State, en); end
        step();
        reset = 1'b1; IR = 16'h0000;
        #1;
        checks++; if (State !== 4'd0 || en !== 6'b111000) begin errors++; $display("FAIL halt_exit_fetch: state=%0d en=%b want 0 111000", State, en); end
        step();
        checks++; if (State !== 4'd1) begin errors++; $display("FAIL halt_exit_decode: got %0d want 1", State); end
    endtask

    initial begin
        test_reset();
        test_mem_alu();
        test_load();
        test_store_addi_jump();
        test_branch();
        test_push_pop();
        test_illegal_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_ctrl_fsm.md
# acc_ctrl_fsm

Multicycle control unit for the 16-bit accumulator processor. It sequences the ALU subsystem (source muxes, ALU operation), PC, IR, ACC, SP and memory enables across fetch, decode and execute states. It decodes IR[15:12] and issues Moore-style control each cycle. The one exception is the branch PC write, which is qualified by the ALU `Zero` flag.

## Interface
- No parameters.
- CLK  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; 0 at a CLK edge forces FETCH.
- IR  in  16  instruction register output; opcode = IR[15:12].
- Zero  in  1  ALU zero flag, combinational from current ALU inputs.
- ALUSrcA  out  3  A-source select: 0 PC, 1 ACC, 2 SP.
- ALUSrcB  out  4  B-source select: 0 constant 2, 1 SE, 2 MDR, 3 ZE, 4 SL1.
- ALUOP  out  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 PASS-A.
- PCWrite  out  1  PC load enable.
- PCSrc  out  1  PC data select: 0 live ALU result, 1 ALUOut register.
- IRWrite  out  1  IR load enable.
- IorD  out  2  memory address select: 0 PC, 1 SP, 2 ZE(IR[11:0]).
- MemRead / MemWrite  out  1 each  memory strobes; MemRead also loads MDR.
- ACCWrite  out  1  ACC load enable.
- ACCSrc  out  1  ACC data select: 0 ALU result, 1 MDR.
- SPWrite  out  1  SP load enable from the live ALU result.
- State  out  4  current state code, for debug.

## Operation
- State codes: FETCH 0, DECODE 1, MEM_RD 2, MEM_ALU 3, LOAD_WB 4, MEM_WR 5, EXEC_I 6, BRANCH 7, JUMP 8, SP_DEC 9, PUSH_WR 10, POP_RD 11, POP_WB 12, HALT 15.
- Default in every state: all enables 0, all selects 0, ALUOP 000. Each state below lists only the outputs that differ from the default.
- FETCH: IorD=0, MemRead, IRWrite, SrcA=0, SrcB=0, ADD, PCWrite, PCSrc=0 (PC+2). Next: DECODE.
- DECODE: SrcA=0, SrcB=4, ADD. ALUOut captures the branch/jump target. Next state by opcode:
  - 0–4 → MEM_RD
  - 5 → MEM_WR
  - 6 → EXEC_I
  - 7 → BRANCH
  - 8 → JUMP
  - 9 → SP_DEC
  - A → POP_RD
  - F → HALT
  - B–E (illegal) → FETCH, executed as a NOP.
- MEM_RD: IorD=2, MemRead. Opcode 4 → LOAD_WB; otherwise → MEM_ALU.
- MEM_ALU: SrcA=1, SrcB=2, ALUOP = opcode (0 ADD, 1 SUB, 2 AND, 3 OR), ACCWrite, ACCSrc=0. Next: FETCH.
- LOAD_WB: ACCWrite, ACCSrc=1. Next: FETCH.
- MEM_WR: IorD=2, MemWrite (stores ACC). Next: FETCH.
- EXEC_I: SrcA=1, SrcB=1, ADD, ACCWrite, ACCSrc=0. Next: FETCH.
- BRANCH: SrcA=1, PASS-A, PCSrc=1, PCWrite=Zero. Next: FETCH.
- JUMP: PCSrc=1, PCWrite. Next: FETCH.
- SP_DEC: SrcA=2, SrcB=0, SUB, SPWrite. Next: PUSH_WR.
- PUSH_WR: IorD=1, MemWrite. Next: FETCH.
- POP_RD: IorD=1, MemRead. Next: POP_WB.
- POP_WB: ACCWrite, ACCSrc=1, SrcA=2, SrcB=0, ADD, SPWrite. Next: FETCH.
- HALT: all enables 0; remains in HALT until reset.
- SP convention: SP points at the top valid entry. PUSH pre-decrements SP by 2; POP reads, then post-increments SP by 2. SP arithmetic wraps modulo 2^16 with no flag.

## Timing
- State register updates on the rising CLK edge. All outputs are decoded from State; PCWrite in BRANCH additionally depends combinationally on Zero.
- While reset=0: State is 0 and all enables (PCWrite, IRWrite, MemRead, MemWrite, ACCWrite, SPWrite) are forced to 0 combinationally; all selects are 0. The first edge with reset=1 executes FETCH.
- Reset asserted in any state, including mid-instruction or HALT: that state is abandoned and no further writes from it occur. State becomes FETCH at the edge.
- Cycles per instruction:
  - MEM-ALU ops and LOAD: 4
  - STORE, ADDI, BEQZ, JUMP: 3
  - PUSH, POP: 4
  - illegal opcode: 2
- IR is stable from the end of FETCH until the next FETCH. Opcode decode in DECODE and later states uses the registered IR only.
- Memory is synchronous: address and strobe are presented in a state, and data/MDR is valid in the following state.

## Test plan
- Reset held low 3 cycles in mid-state POP_WB → State=0, every enable 0 during reset; first post-reset cycle: MemRead=1, IRWrite=1, PCWrite=1, PCSrc=0.
- IR=0x1034 (SUB mem) → State sequence 0,1,2,3,0; in MEM_RD IorD=2, MemRead=1; in MEM_ALU SrcA=1, SrcB=2, ALUOP=001, ACCWrite=1.
- IR=0x7004 with Zero=1, then repeated with Zero=0 → State 0,1,7,0; BRANCH PCWrite=1 with PCSrc=1 in the first run, PCWrite=0 in the second.
- IR=0x9000 then IR=0xA000 → PUSH: 0,1,9,10,0 with SP_DEC SrcA=2, SrcB=0, SUB, SPWrite, and PUSH_WR IorD=1, MemWrite. POP: 0,1,11,12,0 with POP_WB ACCSrc=1, ADD, SPWrite.
- IR=0xC123 (illegal) → 0,1,0 and no ACC/SP/mem writes; IR=0xF000 → HALT (15) held for 20 cycles with all enables 0, exit only via reset=0.
- IR=0x4010 (LOAD) → 0,1,2,4,0; LOAD_WB ACCWrite=1, ACCSrc=1, MemRead=0.
